conv_acc_ctrl: RTL and testbench

Top-level sequencer for the single-image CNN accelerator: 3x3 conv over a 28x28 image, then a 676x10 fully-connected layer, then argmax to an 8-bit class result.
- Starts on i_start and issues conv window positions to the conv datapath under valid/ready.
- Counts returned conv results and generates their feature-RAM write addresses.
- Sequences the FC MAC sweep, then selects FC scores one by one and computes the argmax.
- Sits between the start/result pins of the accelerator top and the conv/FC datapath blocks.

---
 rtl/conv_acc_ctrl.sv | 176 +++++++++++++++++
 tb/tb_conv_acc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : conv_acc_ctrl
//  Purpose  : Top-level sequencer for the single-image CNN accelerator:
//             conv window issue, feature write addressing, FC sweep, argmax.
//  Revision : 1.0  initial release
// ============================================================================
module conv_acc_ctrl #(
    parameter int IMG_W   = 28,
    parameter int K       = 3,
    parameter int N_CLS   = 10,
    parameter int SCORE_W = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [7:0]                o_res,
    output logic                      o_win_valid,
    input  logic                      i_win_ready,
    output logic [4:0]                o_win_row,
    output logic [4:0]                o_win_col,
    input  logic                      i_res_valid,
    output logic [9:0]                o_feat_waddr,
    output logic                      o_fc_en,
    output logic [9:0]                o_fc_idx,
    output logic                      o_fc_first,
    output logic                      o_fc_last,
    input  logic                      i_fc_done,
    output logic [3:0]                o_cls_sel,
    input  logic signed [SCORE_W-1:0] i_fc_score,
    output logic                      o_err
);

    localparam int         c_out_w     = IMG_W - K + 1;
    localparam int         c_n_feat    = c_out_w * c_out_w;
    localparam logic [4:0] c_last_pos  = 5'(c_out_w - 1);
    localparam logic [9:0] c_n_feat_v  = 10'(c_n_feat);
    localparam logic [9:0] c_last_feat = 10'(c_n_feat - 1);
    localparam logic [3:0] c_am_last   = 4'(N_CLS);
    localparam logic [3:0] c_last_cls  = 4'(N_CLS - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_conv    = 3'd1;
    localparam logic [2:0] c_st_drain   = 3'd2;
    localparam logic [2:0] c_st_fc      = 3'd3;
    localparam logic [2:0] c_st_fc_wait = 3'd4;
    localparam logic [2:0] c_st_argmax  = 3'd5;
    localparam logic [2:0] c_st_done    = 3'd6;

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [4:0]                r_row;
    logic [4:0]                r_col;
    logic [9:0]                r_res_cnt;
    logic [9:0]                r_fc_idx;
    logic [3:0]                r_am_cnt;
    logic [3:0]                r_best_idx;
    logic signed [SCORE_W-1:0] r_best_score;
    logic [7:0]                r_res;
    logic                      r_err;

    logic       w_start;
    logic       w_hs;
    logic       w_last_win;
    logic       w_cnt_open;
    logic       w_res_acc;
    logic       w_res_bad;
    logic       w_cnt_full_nxt;
    logic       w_new_best;
    logic [3:0] w_best_idx_nxt;

    assign w_start    = (r_state == c_st_idle) && i_start;
    assign w_hs       = (r_state == c_st_conv) && i_win_ready;
    assign w_last_win = (r_row == c_last_pos) && (r_col == c_last_pos);
    assign w_cnt_open = ((r_state == c_st_conv) || (r_state == c_st_drain)) &&
                        (r_res_cnt != c_n_feat_v);
    assign w_res_acc  = i_res_valid && w_cnt_open;
    assign w_res_bad  = i_res_valid && !w_cnt_open;

    // A result landing in this very cycle completes the count, so zero-latency
    // datapaths go straight from CONV to FC.
    assign w_cnt_full_nxt = (r_res_cnt == c_n_feat_v) ||
                            (w_res_acc && (r_res_cnt == c_last_feat));

    // Count value k samples class k-1; class 0 always seeds the running max.
    assign w_new_best     = (r_state == c_st_argmax) && (r_am_cnt != 4'd0) &&
                            ((r_am_cnt == 4'd1) || (i_fc_score > r_best_score));
    assign w_best_idx_nxt = w_new_best ? (r_am_cnt - 4'd1) : r_best_idx;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (i_start) w_state_nxt = c_st_conv;
            c_st_conv:    if (w_hs && w_last_win)
                              w_state_nxt = w_cnt_full_nxt ? c_st_fc : c_st_drain;
            c_st_drain:   if (w_cnt_full_nxt) w_state_nxt = c_st_fc;
            c_st_fc:      if (r_fc_idx == c_last_feat) w_state_nxt = c_st_fc_wait;
            c_st_fc_wait: if (i_fc_done) w_state_nxt = c_st_argmax;
            c_st_argmax:  if (r_am_cnt == c_am_last) w_state_nxt = c_st_done;
            c_st_done:    w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_row        <= '0;
            r_col        <= '0;
            r_res_cnt    <= '0;
            r_fc_idx     <= '0;
            r_am_cnt     <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_res        <= '0;
            r_err        <= 1'b0;
        end else if (w_start) begin
            r_row        <= '0;
            r_col        <= '0;
            r_res_cnt    <= '0;
            r_fc_idx     <= '0;
            r_am_cnt     <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_hs) begin
                if (r_col == c_last_pos) begin
                    r_col <= '0;
                    r_row <= (r_row == c_last_pos) ? 5'd0 : r_row + 5'd1;
                end else begin
                    r_col <= r_col + 5'd1;
                end
            end
            if (w_res_acc) r_res_cnt <= r_res_cnt + 10'd1;
            if (w_res_bad) r_err <= 1'b1;
            if (r_state == c_st_fc)
                r_fc_idx <= (r_fc_idx == c_last_feat) ? 10'd0 : r_fc_idx + 10'd1;
            if (r_state == c_st_argmax)
                r_am_cnt <= (r_am_cnt == c_am_last) ? 4'd0 : r_am_cnt + 4'd1;
            if (w_new_best) begin
                r_best_idx   <= w_best_idx_nxt;
                r_best_score <= i_fc_score;
            end
            // Result is published on entry to DONE so it is valid alongside o_done.
            if ((r_state == c_st_argmax) && (r_am_cnt == c_am_last))
                r_res <= {4'b0000, w_best_idx_nxt};
        end
    end

    assign o_busy       = (r_state != c_st_idle);
    assign o_done       = (r_state == c_st_done);
    assign o_res        = r_res;
    assign o_win_valid  = (r_state == c_st_conv);
    assign o_win_row    = r_row;
    assign o_win_col    = r_col;
    assign o_feat_waddr = r_res_cnt;
    assign o_fc_en      = (r_state == c_st_fc);
    assign o_fc_idx     = r_fc_idx;
    assign o_fc_first   = (r_state == c_st_fc) && (r_fc_idx == 10'd0);
    assign o_fc_last    = (r_state == c_st_fc) && (r_fc_idx == c_last_feat);
    assign o_cls_sel    = ((r_state == c_st_argmax) && (r_am_cnt <= c_last_cls)) ?
                          r_am_cnt : 4'd0;
    assign o_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_acc_ctrl
//  Purpose  : Randomized self-checking bench for conv_acc_ctrl against a
//             transaction-level model of the accelerator sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_acc_ctrl;

    localparam int IMG_W   = 28;
    localparam int K       = 3;
    localparam int N_CLS   = 10;
    localparam int SCORE_W = 32;
    localparam int OUT_W   = IMG_W - K + 1;
    localparam int N_FEAT  = OUT_W * OUT_W;
    localparam int MIN_RUN = N_FEAT + N_FEAT + 1 + (N_CLS + 1) + 1;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      start;
    logic                      win_ready;
    logic                      res_valid;
    logic                      fc_done;
    logic signed [SCORE_W-1:0] fc_score;
    logic                      busy;
    logic                      done;
    logic [7:0]                res;
    logic                      win_valid;
    logic [4:0]                win_row;
    logic [4:0]                win_col;
    logic [9:0]                feat_waddr;
    logic                      fc_en;
    logic [9:0]                fc_idx;
    logic                      fc_first;
    logic                      fc_last;
    logic [3:0]                cls_sel;
    logic                      err;

    conv_acc_ctrl #(.IMG_W(IMG_W), .K(K), .N_CLS(N_CLS), .SCORE_W(SCORE_W)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start),
        .o_busy(busy), .o_done(done), .o_res(res),
        .o_win_valid(win_valid), .i_win_ready(win_ready),
        .o_win_row(win_row), .o_win_col(win_col),
        .i_res_valid(res_valid), .o_feat_waddr(feat_waddr),
        .o_fc_en(fc_en), .o_fc_idx(fc_idx), .o_fc_first(fc_first), .o_fc_last(fc_last),
        .i_fc_done(fc_done), .o_cls_sel(cls_sel), .i_fc_score(fc_score), .o_err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-run model inputs, set by the stimulus before each start
    int scores [N_CLS];
    int model_best;
    int lit;
    bit chk_min;
    int exp_wait;

    // Model state tracked by the compare process
    bit         exp_busy  = 0;
    bit         exp_err   = 0;
    int         res_hold  = 0;
    int         hs_cnt    = 0;
    int         rs_cnt    = 0;
    int         fc_cnt    = 0;
    bit         wait_fc   = 0;
    int         last_cyc  = 0;
    int         am_start  = -1;
    int         run_first = 0;
    bit         prev_stall = 0;
    logic [4:0] prev_row  = '0;
    logic [4:0] prev_col  = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_busy = 0; exp_err = 0; res_hold = 0; hs_cnt = 0; rs_cnt = 0;
            fc_cnt = 0; wait_fc = 0; am_start = -1; prev_stall = 0;
        end else begin
            check("busy", busy, exp_busy);
            check("err", err, exp_err);
            check("win_valid", win_valid, exp_busy && hs_cnt < N_FEAT);

            if (win_valid) begin
                if (prev_stall) begin
                    check("stall_row", win_row, prev_row);
                    check("stall_col", win_col, prev_col);
                end
                if (win_ready) begin
                    check("win_row", win_row, hs_cnt / OUT_W);
                    check("win_col", win_col, hs_cnt % OUT_W);
                    hs_cnt++;
                end
                prev_stall = !win_ready;
                prev_row   = win_row;
                prev_col   = win_col;
            end else begin
                prev_stall = 0;
            end

            if (res_valid) begin
                if (exp_busy && rs_cnt < N_FEAT) begin
                    check("waddr", feat_waddr, rs_cnt);
                    rs_cnt++;
                end else begin
                    check("waddr_sat", feat_waddr, N_FEAT);
                    exp_err = 1;
                end
            end

            if (wait_fc && fc_done && am_start < 0) am_start = cyc + 1;

            if (fc_en || (fc_cnt > 0 && fc_cnt < N_FEAT)) begin
                check("fc_en", fc_en, 1);
                check("fc_idx", fc_idx, fc_cnt);
                check("fc_first", fc_first, fc_cnt == 0);
                check("fc_last", fc_last, fc_cnt == N_FEAT - 1);
                check("fc_after_conv", hs_cnt == N_FEAT && rs_cnt == N_FEAT, 1);
                if (fc_cnt == N_FEAT - 1) begin
                    wait_fc  = 1;
                    last_cyc = cyc;
                end
                fc_cnt++;
            end

            if (am_start >= 0 && cyc >= am_start && cyc <= am_start + N_CLS - 1)
                check("cls_sel", cls_sel, cyc - am_start);

            check("done", done, am_start >= 0 && cyc == am_start + N_CLS + 1);

            if (am_start >= 0 && cyc == am_start + N_CLS + 1) begin
                check("res", res, model_best);
                if (lit >= 0) check("res_literal", res, lit);
                check("hs_total", hs_cnt, N_FEAT);
                check("res_total", rs_cnt, N_FEAT);
                check("fc_total", fc_cnt, N_FEAT);
                check("fc_wait_len", am_start - 1 - last_cyc, exp_wait);
                if (chk_min) check("run_len", cyc - run_first + 1, MIN_RUN);
                res_hold = model_best;
                exp_busy = 0;
                am_start = -1;
                wait_fc  = 0;
            end else begin
                check("res_hold", res, res_hold);
            end

            if (start && !exp_busy && !busy) begin
                exp_busy  = 1;
                exp_err   = 0;
                hs_cnt    = 0;
                rs_cnt    = 0;
                fc_cnt    = 0;
                wait_fc   = 0;
                am_start  = -1;
                run_first = cyc + 1;
            end
        end
    end

    // One full run; entered and left at #1 after a rising edge.
    task automatic run(input int rmode, input int lat, input int dly, input int lit_in,
                       input bit extra, input bit busy_start, input bit rst37, input bit minchk);
        int  q[$];
        int  last_seen;
        int  prev_sel;
        int  pat;
        bit  dn;
        bit  extra_done;
        bit  aborted;
        model_best = 0;
        for (int i = 1; i < N_CLS; i++)
            if (scores[i] > scores[model_best]) model_best = i;
        lit        = lit_in;
        chk_min    = minchk;
        exp_wait   = (dly < 1) ? 1 : dly;
        last_seen  = -1;
        prev_sel   = 0;
        pat        = 0;
        dn         = 0;
        extra_done = 0;
        aborted    = 0;
        for (int n = 0; n < 6000 && !dn && !aborted; n++) begin
            if (done) dn = 1;
            if (rst37 && win_valid && win_row == 5'd3 && win_col == 5'd7) begin
                rstn = 0; start = 0; win_ready = 0; res_valid = 0; fc_done = 0;
                @(posedge clk); #1;
                rstn = 1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_win_valid", win_valid, 0);
                check("rst_res", res, res_hold);
                aborted = 1;
            end else begin
                start = (n == 0) || (busy_start && n == 100);
                case (rmode)
                    0:       win_ready = 1'b1;
                    1:       win_ready = (pat % 4 == 0) || (pat % 4 == 3);
                    default: win_ready = ($urandom_range(0, 2) != 0);
                endcase
                pat++;
                if (win_valid && win_ready) q.push_back(cyc + lat);
                res_valid = 1'b0;
                if (q.size() > 0 && q[0] == cyc) begin
                    res_valid = 1'b1;
                    void'(q.pop_front());
                end
                if (extra && fc_en && !extra_done) begin
                    res_valid  = 1'b1;
                    extra_done = 1;
                end
                if (fc_last) last_seen = cyc;
                fc_done  = (dly == 0) ? 1'b1 : (last_seen >= 0 && cyc >= last_seen + dly);
                fc_score = (prev_sel < N_CLS) ? scores[prev_sel] : 0;
                prev_sel = int'(cls_sel);
                @(posedge clk); #1;
            end
        end
        if (!dn && !aborted) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got no o_done expected o_done within budget");
        end
        start = 0; win_ready = 0; res_valid = 0; fc_done = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 0; start = 0; win_ready = 0; res_valid = 0; fc_done = 0; fc_score = '0;
        #3;
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_res0", res, 0);
        check("rst_win_valid0", win_valid, 0);
        check("rst_row0", win_row, 0);
        check("rst_col0", win_col, 0);
        check("rst_waddr0", feat_waddr, 0);
        check("rst_fc_en0", fc_en, 0);
        check("rst_fc_idx0", fc_idx, 0);
        check("rst_fc_first0", fc_first, 0);
        check("rst_fc_last0", fc_last, 0);
        check("rst_cls_sel0", cls_sel, 0);
        check("rst_err0", err, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        @(posedge clk); #1;

        // Abort mid-CONV at window (3,7), then a minimum-length run
        scores = '{4, 1, 7, 0, 0, 0, 0, 0, 0, 0};
        run(0, 2, 0, -1, 0, 0, 1, 0);
        for (int i = 0; i < N_CLS; i++) scores[i] = int'($urandom_range(0, 8)) - 4;
        run(0, 0, 0, -1, 0, 0, 0, 1);

        scores = '{-5, 3, 9, 9, -100, 0, 1, 2, 8, 7};
        run(0, 2, 0, 2, 0, 0, 0, 0);

        for (int i = 0; i < N_CLS; i++) scores[i] = -1;
        run(1, 1, 20, 0, 0, 1, 0, 0);

        for (int i = 0; i < N_CLS; i++) scores[i] = i;
        run(2, 3, 3, 9, 1, 0, 0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N_CLS; i++)
                scores[i] = (r == 3) ? int'($urandom) : int'($urandom_range(0, 6)) - 3;
            run(2, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), -1,
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
